// File: rtl/nic_if.sv
// Processor-access and router-link signals of the NIC, bundled as one port.
// The master modport is the environment (processor plus router); the slave
// modport is the NIC core itself.
interface nic_if;
    // Processor register-access side
    logic        nicEn;
    logic        nicEnWr;
    logic [1:0]  adder_nic;
    logic [63:0] d_in;
    logic [63:0] d_out;

    // Router side, packets flowing into the NIC
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;

    // Router side, packets flowing out of the NIC
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;

    modport master (
        output nicEn, nicEnWr, adder_nic, d_in, net_si, net_di, net_ro,
        input  d_out, net_ri, net_so, net_do
    );

    modport slave (
        input  nicEn, nicEnWr, adder_nic, d_in, net_si, net_di, net_ro,
        output d_out, net_ri, net_so, net_do
    );
endinterface

// File: rtl/nic_core.sv
// Single-entry network interface: one 64-bit input buffer filled by the router
// and drained by processor reads, one 64-bit output buffer filled by processor
// writes and drained by the router. Each buffer has a full flag that doubles
// as the handshake toward the side that fills it.
module nic_core (
    input  logic  clk,
    input  logic  reset,
    nic_if.slave  nic
);

    // Register map seen by the processor
    typedef enum logic [1:0] {
        SEL_IN_DATA  = 2'b00,
        SEL_IN_STAT  = 2'b01,
        SEL_OUT_DATA = 2'b10,
        SEL_OUT_STAT = 2'b11
    } reg_sel_e;

    reg_sel_e    sel;

    logic [63:0] in_buf_q,   in_buf_d;
    logic        in_full_q,  in_full_d;
    logic [63:0] out_buf_q,  out_buf_d;
    logic        out_full_q, out_full_d;

    logic        proc_rd;
    logic        proc_wr;
    logic        in_capture;
    logic        in_consume;
    logic        out_load;
    logic        out_drain;

    assign sel     = reg_sel_e'(nic.adder_nic);
    assign proc_rd = nic.nicEn & ~nic.nicEnWr;
    assign proc_wr = nic.nicEn &  nic.nicEnWr;

    // Transfer events; each is qualified by the flag of the buffer it touches,
    // so an offer to a full buffer or a read of an empty one is a no-op.
    // Capture and consume cannot coincide: capture needs the input buffer
    // empty, consume needs it full. Likewise for load and drain on the output.
    assign in_capture = nic.net_si & ~in_full_q;
    assign in_consume = proc_rd & (sel == SEL_IN_DATA) & in_full_q;
    assign out_load   = proc_wr & (sel == SEL_OUT_DATA) & ~out_full_q;
    assign out_drain  = out_full_q & nic.net_ro;

    // Handshake outputs come straight from the full flags and the output buffer.
    assign nic.net_ri = ~in_full_q;
    assign nic.net_so = out_full_q;
    assign nic.net_do = out_buf_q;

    // Processor read mux; non-read cycles return zero.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case leaves it unassigned and a latch is never inferred.
        nic.d_out = 64'b0;
        if (proc_rd) begin
            unique case (sel)
                SEL_IN_DATA:  nic.d_out = in_buf_q;
                SEL_IN_STAT:  nic.d_out = {63'b0, in_full_q};
                SEL_OUT_DATA: nic.d_out = 64'b0;
                SEL_OUT_STAT: nic.d_out = {63'b0, out_full_q};
                default:      nic.d_out = 64'b0;
            endcase
        end
    end

    // Input path next state: router fills, processor read of 00 empties.
    // A read of an empty buffer leaves data and flag alone (stale contents).
    always_comb begin
        in_buf_d  = in_buf_q;
        in_full_d = in_full_q;
        if (in_capture) begin
            in_buf_d  = nic.net_di;
            in_full_d = 1'b1;
        end else if (in_consume) begin
            in_full_d = 1'b0;
        end
    end

    // Output path next state: processor write of 10 fills, router drains.
    // A write landing in a drain cycle sees the buffer full and is dropped;
    // the drained data stays in the buffer, only the flag falls.
    always_comb begin
        out_buf_d  = out_buf_q;
        out_full_d = out_full_q;
        if (out_load) begin
            out_buf_d  = nic.d_in;
            out_full_d = 1'b1;
        end else if (out_drain) begin
            out_full_d = 1'b0;
        end
    end

    // State registers for both paths; reset discards any buffered packet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the data buffers are reset too, not just the flags, because
            // net_do and a stale read of 00 expose them directly and must read
            // zero after reset.
            in_buf_q   <= 64'b0;
            in_full_q  <= 1'b0;
            out_buf_q  <= 64'b0;
            out_full_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of every other register, independent of order.
            in_buf_q   <= in_buf_d;
            in_full_q  <= in_full_d;
            out_buf_q  <= out_buf_d;
            out_full_q <= out_full_d;
        end
    end

endmodule
